usbfs_endp_tx_multi: RTL
========================

Name: usbfs_endp_tx_multi

Overview:
Parametrised multi-channel device-to-host bulk endpoint packetiser for the USB full-speed device stack. It sits between N_CH independent byte-stream sources and the transmit-endpoint ports of the transaction layer (etReady/etValid/etData/etData_nBytes/etStall), one endpoint per channel. Each channel gathers bytes into a packet of at most MAX_PKT bytes. It adds an idle-timeout flush, an explicit flush request, and zero-length-packet (ZLP) termination, which the single-channel serial transmit endpoint lacks.

Parameters:
N_CH, 2, number of independent channels/IN endpoints (>=1)
MAX_PKT, 8, wMaxPacketSize in bytes, one of {8,16,32,64}
FLUSH_CYCLES, 48000, idle cycles before a partial packet is sent (1 ms at 48 MHz); 0 disables the timeout
ZLP_EN, 1, 1 = send a ZLP to terminate a transfer whose last packet was exactly MAX_PKT

Ports:
i_clk  input  1  clock (48 MHz in the USB domain)
i_rst  input  1  reset, asynchronous, active-high
o_ready  output  N_CH  per-channel byte-accept ready
i_valid  input  N_CH  per-channel byte valid
i_data  input  N_CH*8  per-channel byte, channel c at [8*c +: 8]
i_flush  input  N_CH  per-channel request to send the current partial packet
i_stall  input  N_CH  per-channel stall request
i_etReady  input  N_CH  transaction layer consumed packet
o_etValid  output  N_CH  packet available
o_etData  output  N_CH*8*MAX_PKT  packet bytes, channel c at [c*8*MAX_PKT +: 8*MAX_PKT], byte k at [8*k +: 8]
o_etData_nBytes  output  N_CH*$clog2(MAX_PKT+1)  packet length, 0..MAX_PKT
o_etStall  output  N_CH  registered i_stall

Behaviour:
- Channels are fully independent (per-channel generate). There is no arbitration between channels.
- Reset, asynchronous: all registers clear at once. o_ready=0 during reset and 1 in the first cycle after release. o_etValid=0, o_etData=0, o_etData_nBytes=0, o_etStall=0. zlpPending=0, timer=0, state=FILL. Reset mid-packet discards the buffered bytes.
- States per channel: FILL and SEND.
- FILL:
  - o_ready=1 iff count<MAX_PKT.
  - Accepting a byte (i_valid&o_ready) writes it to byte index count, increments count, clears the timer and clears zlpPending.
- Timer:
  - Increments in FILL on cycles with no accept and saturates at FLUSH_CYCLES.
  - Width is $clog2(FLUSH_CYCLES+1).
- Transition FILL->SEND at the next edge when o_etStall=0 and any of the following holds:
  - count==MAX_PKT.
  - FLUSH_CYCLES>0, count>0, and the timer reaches FLUSH_CYCLES.
  - i_flush=1 and count>0.
  - zlpPending=1 and (timer reaches FLUSH_CYCLES or i_flush=1). This sends a ZLP with nBytes=0.
- Priority: an accept in the same cycle as a timeout or flush wins. The byte is stored, the timer clears, and a flush includes the new byte.
- Latency:
  - The byte filling the packet, accepted at edge t, gives o_etValid=1 after edge t+1.
  - Timeout: o_etValid rises FLUSH_CYCLES+1 edges after the edge that accepted the last byte.
  - i_flush sampled at edge t gives o_etValid=1 after edge t+1.
- SEND:
  - o_ready=0 and o_etValid=1.
  - o_etData and o_etData_nBytes stay stable until the handshake.
- Handshake (o_etValid&i_etReady):
  - Next state is FILL with count=0, the buffer zeroed and the timer=0.
  - zlpPending is set iff ZLP_EN=1 and the sent nBytes==MAX_PKT. Otherwise it is cleared.
  - Bytes at index >= nBytes are always 0.
- Stall:
  - o_etStall<=i_stall each cycle.
  - While o_etStall=1, FILL->SEND is suppressed, but FILL still accepts bytes up to MAX_PKT.
  - A channel already in SEND stays in SEND.
- i_flush has no effect with count==0 and zlpPending==0, or in SEND.

Test Plan:
1. N_CH=2, MAX_PKT=8, i_etReady=0. Stream 8 bytes 0x01..0x08 on ch0 → o_etValid[0] rises one cycle after the 8th accept. nBytes=8, data=0x0807060504030201, o_ready[0]=0. Ch1 remains idle.
2. FLUSH_CYCLES=4. Send 3 bytes 0xA0..0xA2 on ch1, then idle → o_etValid[1] rises 5 edges after the last accept with nBytes=3 and upper bytes 0. Handshake → count=0, o_ready[1]=1.
3. ZLP_EN=1, FLUSH_CYCLES=4. Send 8 bytes, handshake, idle → ZLP presented with nBytes=0 five edges after the handshake. After its handshake, no further ZLP. Repeat with ZLP_EN=0 → no ZLP.
4. 2 bytes buffered, i_stall=1, then i_flush pulses → no o_etValid. Release stall, pulse i_flush → o_etValid with nBytes=2 two edges after the flush.
5. Assert i_rst asynchronously while ch0 is in SEND with 5 bytes → o_etValid[0]=0 and nBytes=0 immediately. After release, the first packet contains only new bytes.
6. Both channels fill to MAX_PKT simultaneously with i_etReady toggled randomly → each channel's packets are delivered in order, data is intact, and there is no cross-channel interference.

Source files
------------

// File: rtl/usbfs_endp_tx_multi.sv
// Multi-channel bulk IN packetiser. Each channel gathers a byte stream into packets of up to MAX_PKT
// bytes and sends them when full, after an idle timeout, on an explicit flush, or as a terminating ZLP.
module usbfs_endp_tx_multi #(
    parameter int N_CH         = 2,
    parameter int MAX_PKT      = 8,
    parameter int FLUSH_CYCLES = 48000,
    parameter int ZLP_EN       = 1
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    output logic [N_CH-1:0]                     o_ready,
    input  logic [N_CH-1:0]                     i_valid,
    input  logic [N_CH*8-1:0]                   i_data,
    input  logic [N_CH-1:0]                     i_flush,
    input  logic [N_CH-1:0]                     i_stall,
    input  logic [N_CH-1:0]                     i_etReady,
    output logic [N_CH-1:0]                     o_etValid,
    output logic [N_CH*8*MAX_PKT-1:0]           o_etData,
    output logic [N_CH*$clog2(MAX_PKT+1)-1:0]   o_etData_nBytes,
    output logic [N_CH-1:0]                     o_etStall
);

    localparam int CW = $clog2(MAX_PKT + 1);
    localparam int TW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam int PW = 8 * MAX_PKT;
    localparam logic [CW-1:0] FULL  = CW'(MAX_PKT);
    localparam logic [TW-1:0] T_MAX = TW'(FLUSH_CYCLES);

    typedef enum logic {FILL, SEND} state_t;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_t          state_q, state_d;
        logic [CW-1:0]   count_q, count_d;
        logic [PW-1:0]   pkt_q, pkt_d;
        logic [TW-1:0]   timer_q, timer_d;
        logic            zlp_q, zlp_d;
        logic            flush_q, flush_d;
        logic            ready_q, ready_d;
        logic            stall_q;
        logic            accept;
        logic            timeout;

        assign accept  = ready_q & i_valid[c];
        assign timeout = (FLUSH_CYCLES > 0) && (timer_q == T_MAX);

        always_comb begin
            // NOTE: every next-state variable gets a default first so no path can infer a latch.
            state_d = state_q;
            count_d = count_q;
            pkt_d   = pkt_q;
            timer_d = timer_q;
            zlp_d   = zlp_q;
            flush_d = (state_q == FILL) && i_flush[c];
            case (state_q)
                FILL: begin
                    if (accept) begin
                        for (int k = 0; k < MAX_PKT; k++) begin
                            if (count_q == CW'(k)) pkt_d[8*k +: 8] = i_data[8*c +: 8];
                        end
                        count_d = count_q + 1'b1;
                        timer_d = '0;
                        zlp_d   = 1'b0;
                        // An accept beats a pending flush; the flush is retried with the new byte included.
                        flush_d = flush_d | (flush_q && ((count_q != '0) || zlp_q));
                    end else begin
                        if (timer_q != T_MAX) timer_d = timer_q + 1'b1;
                        if (!stall_q && ((count_q == FULL) ||
                            (((count_q != '0) || zlp_q) && (timeout || flush_q)))) begin
                            state_d = SEND;
                        end
                    end
                end
                SEND: begin
                    if (i_etReady[c]) begin
                        state_d = FILL;
                        count_d = '0;
                        pkt_d   = '0;
                        timer_d = '0;
                        zlp_d   = (ZLP_EN != 0) && (count_q == FULL);
                    end
                end
            endcase
            ready_d = (state_d == FILL) && (count_d != FULL);
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                state_q <= FILL;
                count_q <= '0;
                pkt_q   <= '0;
                timer_q <= '0;
                zlp_q   <= 1'b0;
                flush_q <= 1'b0;
                ready_q <= 1'b0;
                stall_q <= 1'b0;
            end else begin
                state_q <= state_d;
                count_q <= count_d;
                pkt_q   <= pkt_d;
                timer_q <= timer_d;
                zlp_q   <= zlp_d;
                flush_q <= flush_d;
                ready_q <= ready_d;
                stall_q <= i_stall[c];
            end
        end

        assign o_ready[c]                   = ready_q;
        assign o_etValid[c]                 = (state_q == SEND);
        assign o_etData[c*PW +: PW]         = pkt_q;
        assign o_etData_nBytes[c*CW +: CW]  = count_q;
        assign o_etStall[c]                 = stall_q;
    end

endmodule
